// File: rtl/ram_arbiter_if.sv
// Signal bundle around ram_arbiter: CPU fetch port, host loader/debug port and RAM macro side.
// slave is the arbiter's view; master is the surrounding system (CPU, host, RAM).
interface ram_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_addr,
        output cpu_ack, cpu_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_addr,
        input  cpu_ack, cpu_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares the single-port program RAM between CPU fetch and host loader with a fixed issue/capture
// pipeline. Round-robin on ties by default; define RAM_ARB_HOST_PRIO_EN for fixed host priority.
module ram_arbiter #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ram_arbiter_if.slave io_bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;
    typedef enum logic {OwnCpu, OwnHost} owner_e;

    state_e        r_state, w_state_nxt;
    owner_e        r_owner, w_owner_nxt;
    logic          r_write, w_write_nxt;
    logic          r_ram_en, w_ram_en_nxt;
    logic          r_ram_we, w_ram_we_nxt;
    logic [AW-1:0] r_ram_addr, w_ram_addr_nxt;
    logic [DW-1:0] r_ram_wdata, w_ram_wdata_nxt;
    logic          r_cpu_ack, w_cpu_ack_nxt;
    logic          r_host_ack, w_host_ack_nxt;
    logic [DW-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
    logic [DW-1:0] r_host_rdata, w_host_rdata_nxt;

    logic w_cpu_elig;
    logic w_host_elig;
    logic w_grant_any;
    logic w_grant_host;

    // A requester still holding req in its own ack cycle is not a new request yet.
    assign w_cpu_elig  = io_bus.cpu_req & ~r_cpu_ack;
    assign w_host_elig = io_bus.host_req & ~r_host_ack;
    assign w_grant_any = w_cpu_elig | w_host_elig;

`ifdef RAM_ARB_HOST_PRIO_EN
    assign w_grant_host = w_host_elig;
`else
    owner_e r_last_grant;

    assign w_grant_host = w_host_elig & (~w_cpu_elig | (r_last_grant == OwnCpu));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= OwnHost;
        end else if ((r_state == StIdle) && w_grant_any) begin
            r_last_grant <= w_owner_nxt;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_write_nxt      = r_write;
        w_ram_en_nxt     = 1'b0;
        w_ram_we_nxt     = 1'b0;
        w_ram_addr_nxt   = r_ram_addr;
        w_ram_wdata_nxt  = r_ram_wdata;
        w_cpu_ack_nxt    = 1'b0;
        w_host_ack_nxt   = 1'b0;
        w_cpu_rdata_nxt  = r_cpu_rdata;
        w_host_rdata_nxt = r_host_rdata;

        unique case (r_state)
            StIdle: begin
                if (w_grant_any) begin
                    w_state_nxt  = StIssue;
                    w_ram_en_nxt = 1'b1;
                    if (w_grant_host) begin
                        w_owner_nxt     = OwnHost;
                        w_write_nxt     = io_bus.host_we;
                        w_ram_we_nxt    = io_bus.host_we;
                        w_ram_addr_nxt  = io_bus.host_addr;
                        w_ram_wdata_nxt = io_bus.host_wdata;
                    end else begin
                        w_owner_nxt    = OwnCpu;
                        w_write_nxt    = 1'b0;
                        w_ram_addr_nxt = io_bus.cpu_addr;
                    end
                end
            end
            StIssue: begin
                w_state_nxt = StCapture;
            end
            StCapture: begin
                w_state_nxt = StIdle;
                if (r_owner == OwnHost) begin
                    w_host_ack_nxt = 1'b1;
                    if (!r_write) begin
                        w_host_rdata_nxt = io_bus.ram_rdata;
                    end
                end else begin
                    w_cpu_ack_nxt   = 1'b1;
                    w_cpu_rdata_nxt = io_bus.ram_rdata;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_owner      <= OwnCpu;
            r_write      <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_host_ack   <= 1'b0;
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_write      <= w_write_nxt;
            r_ram_en     <= w_ram_en_nxt;
            r_ram_we     <= w_ram_we_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_wdata  <= w_ram_wdata_nxt;
            r_cpu_ack    <= w_cpu_ack_nxt;
            r_host_ack   <= w_host_ack_nxt;
            r_cpu_rdata  <= w_cpu_rdata_nxt;
            r_host_rdata <= w_host_rdata_nxt;
        end
    end

    assign io_bus.ram_en     = r_ram_en;
    assign io_bus.ram_we     = r_ram_we;
    assign io_bus.ram_addr   = r_ram_addr;
    assign io_bus.ram_wdata  = r_ram_wdata;
    assign io_bus.cpu_ack    = r_cpu_ack;
    assign io_bus.cpu_rdata  = r_cpu_rdata;
    assign io_bus.host_ack   = r_host_ack;
    assign io_bus.host_rdata = r_host_rdata;

endmodule
